// File: rtl/up_tpl_regmap_agg.sv
// up-bus request aggregator: broadcasts one request to NUM_SLAVES
// register slaves, merges acks and read data, adds a timeout watchdog.
// Ports: up_* upstream up-bus (up_clk, async active-low up_rstn),
//        s_* broadcast request / per-slave ack and read data.
// Optional macro UP_TPL_REGMAP_AGG_STATS_EN: fault counters plus a
// local stats register at LOCAL_ADDR ({8'd0, late, collision, timeout}).
module up_tpl_regmap_agg #(
  parameter int unsigned           NUM_SLAVES = 4,
  parameter int unsigned           ADDR_WIDTH = 14,
  parameter int unsigned           TIMEOUT    = 255,
  parameter logic [31:0]           ERR_RDATA  = 32'hDEADDEAD,
  parameter bit                    REG_REQ    = 1'b1,
  parameter logic [ADDR_WIDTH-1:0] LOCAL_ADDR = 14'h3FFF
) (
  input  logic                       up_clk,
  input  logic                       up_rstn,
  input  logic                       up_wreq,
  input  logic [ADDR_WIDTH-1:0]      up_waddr,
  input  logic [31:0]                up_wdata,
  output logic                       up_wack,
  input  logic                       up_rreq,
  input  logic [ADDR_WIDTH-1:0]      up_raddr,
  output logic [31:0]                up_rdata,
  output logic                       up_rack,
  output logic                       s_wreq,
  output logic [ADDR_WIDTH-1:0]      s_waddr,
  output logic [31:0]                s_wdata,
  input  logic [NUM_SLAVES-1:0]      s_wack,
  output logic                       s_rreq,
  output logic [ADDR_WIDTH-1:0]      s_raddr,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_rack
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int WR = 0;
  localparam int RD = 1;

  state_e                state_q [2];
  state_e                state_d [2];
  logic [15:0]           tmr_q   [2];
  logic [15:0]           tmr_d   [2];
  logic [ADDR_WIDTH-1:0] addr_q  [2];
  logic [ADDR_WIDTH-1:0] addr_d  [2];
  logic                  sreq_q  [2];
  logic                  sreq_d  [2];
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  req     [2];
  logic [ADDR_WIDTH-1:0] addr_in [2];
  logic [NUM_SLAVES-1:0] acks    [2];
  logic                  ack     [2];
  logic                  multi   [2];
  logic [31:0]           rd_or;

`ifdef UP_TPL_REGMAP_AGG_STATS_EN
  logic       local_q [2];
  logic       local_d [2];
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] col_q, col_d;
  logic [7:0] late_q, late_d;
  logic [1:0] n_tmo, n_col, n_late;
  logic       clr;

  function automatic logic [7:0] sat_add(
    input logic [7:0] c,
    input logic [1:0] n
  );
    logic [8:0] s;
    s = {1'b0, c} + {7'd0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
`endif

  assign req[WR]     = up_wreq;
  assign req[RD]     = up_rreq;
  assign addr_in[WR] = up_waddr;
  assign addr_in[RD] = up_raddr;
  assign acks[WR]    = s_wack;
  assign acks[RD]    = s_rack;

  always_comb begin
    rd_or = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      rd_or = rd_or | s_rdata[32*k +: 32];
    end
    for (int p = 0; p < 2; p++) begin
      ack[p]   = |acks[p];
      // more than one bit set: clearing the lowest set bit leaves some
      multi[p] = |(acks[p] & (acks[p] - NUM_SLAVES'(1)));
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      tmr_d[p]   = tmr_q[p];
      addr_d[p]  = addr_q[p];
      sreq_d[p]  = 1'b0;
    end
    wdata_d = wdata_q;
    rdata_d = '0;
`ifdef UP_TPL_REGMAP_AGG_STATS_EN
    for (int p = 0; p < 2; p++) begin
      local_d[p] = local_q[p];
    end
    n_tmo  = '0;
    n_col  = '0;
    n_late = '0;
    clr    = 1'b0;
`endif
    for (int p = 0; p < 2; p++) begin
      unique case (state_q[p])
        IDLE: begin
`ifdef UP_TPL_REGMAP_AGG_STATS_EN
          if (ack[p]) n_late = n_late + 2'd1;
`endif
          if (req[p]) begin
            state_d[p] = WAIT;
            tmr_d[p]   = '0;
            addr_d[p]  = addr_in[p];
            sreq_d[p]  = 1'b1;
            if (p == WR) wdata_d = up_wdata;
`ifdef UP_TPL_REGMAP_AGG_STATS_EN
            local_d[p] = (addr_in[p] == LOCAL_ADDR);
`endif
          end
        end
        WAIT: begin
          tmr_d[p] = tmr_q[p] + 16'd1;
`ifdef UP_TPL_REGMAP_AGG_STATS_EN
          // local register answers on the first WAIT cycle, never times out
          if (local_q[p]) begin
            state_d[p] = RESP;
            if (ack[p]) n_col = n_col + 2'd1;
            if (p == RD) rdata_d = {8'd0, late_q, col_q, tmo_q} | rd_or;
            if (p == WR && wdata_q[0]) clr = 1'b1;
          end else
`endif
          if (ack[p]) begin
            // a real ack on the expiry cycle wins over the watchdog
            state_d[p] = RESP;
            if (p == RD) rdata_d = rd_or;
`ifdef UP_TPL_REGMAP_AGG_STATS_EN
            if (multi[p]) n_col = n_col + 2'd1;
`endif
          end else if (tmr_q[p] == 16'(TIMEOUT - 1)) begin
            state_d[p] = RESP;
            if (p == RD) rdata_d = ERR_RDATA;
`ifdef UP_TPL_REGMAP_AGG_STATS_EN
            n_tmo = n_tmo + 2'd1;
`endif
          end
        end
        RESP: begin
          state_d[p] = IDLE;
`ifdef UP_TPL_REGMAP_AGG_STATS_EN
          if (ack[p]) n_late = n_late + 2'd1;
`endif
        end
        default: state_d[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= IDLE;
        tmr_q[p]   <= '0;
        addr_q[p]  <= '0;
        sreq_q[p]  <= 1'b0;
      end
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        tmr_q[p]   <= tmr_d[p];
        addr_q[p]  <= addr_d[p];
        sreq_q[p]  <= sreq_d[p];
      end
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef UP_TPL_REGMAP_AGG_STATS_EN
  always_comb begin
    tmo_d  = sat_add(tmo_q, n_tmo);
    col_d  = sat_add(col_q, n_col);
    late_d = sat_add(late_q, n_late);
    if (clr) begin
      tmo_d  = '0;
      col_d  = '0;
      late_d = '0;
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      local_q[WR] <= 1'b0;
      local_q[RD] <= 1'b0;
      tmo_q       <= '0;
      col_q       <= '0;
      late_q      <= '0;
    end else begin
      local_q[WR] <= local_d[WR];
      local_q[RD] <= local_d[RD];
      tmo_q       <= tmo_d;
      col_q       <= col_d;
      late_q      <= late_d;
    end
  end
`endif

  assign up_wack  = (state_q[WR] == RESP);
  assign up_rack  = (state_q[RD] == RESP);
  // only loaded on the read transition into RESP, so 0 otherwise
  assign up_rdata = rdata_q;

  if (REG_REQ) begin : g_reg
    assign s_wreq  = sreq_q[WR];
    assign s_rreq  = sreq_q[RD];
    assign s_waddr = addr_q[WR];
    assign s_raddr = addr_q[RD];
    assign s_wdata = wdata_q;
  end else begin : g_comb
    logic w_acc, r_acc;
    assign w_acc   = up_wreq && (state_q[WR] == IDLE);
    assign r_acc   = up_rreq && (state_q[RD] == IDLE);
    assign s_wreq  = w_acc;
    assign s_rreq  = r_acc;
    assign s_waddr = w_acc ? up_waddr : addr_q[WR];
    assign s_raddr = r_acc ? up_raddr : addr_q[RD];
    assign s_wdata = w_acc ? up_wdata : wdata_q;
  end

endmodule

// File: tb/tb_up_tpl_regmap_agg.sv
// Bench for up_tpl_regmap_agg: directed and random transactions
// checked against a transaction-level model of acks, data and counters.
module tb_up_tpl_regmap_agg;

  localparam int          NS    = 4;
  localparam int          AW    = 14;
  localparam int          T     = 16;
  localparam logic [31:0] ERR   = 32'hDEADDEAD;
  localparam logic [AW-1:0] LADDR = 14'h3FFF;
`ifdef UP_TPL_REGMAP_AGG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              up_clk = 1'b0;
  logic              up_rstn;
  logic              up_wreq;
  logic [AW-1:0]     up_waddr;
  logic [31:0]       up_wdata;
  logic              up_wack;
  logic              up_rreq;
  logic [AW-1:0]     up_raddr;
  logic [31:0]       up_rdata;
  logic              up_rack;
  logic              s_wreq;
  logic [AW-1:0]     s_waddr;
  logic [31:0]       s_wdata;
  logic [NS-1:0]     s_wack;
  logic              s_rreq;
  logic [AW-1:0]     s_raddr;
  logic [NS*32-1:0]  s_rdata;
  logic [NS-1:0]     s_rack;

  up_tpl_regmap_agg #(
    .NUM_SLAVES(NS),
    .ADDR_WIDTH(AW),
    .TIMEOUT(T),
    .ERR_RDATA(ERR),
    .REG_REQ(1'b1),
    .LOCAL_ADDR(LADDR)
  ) dut (
    .up_clk(up_clk),
    .up_rstn(up_rstn),
    .up_wreq(up_wreq),
    .up_waddr(up_waddr),
    .up_wdata(up_wdata),
    .up_wack(up_wack),
    .up_rreq(up_rreq),
    .up_raddr(up_raddr),
    .up_rdata(up_rdata),
    .up_rack(up_rack),
    .s_wreq(s_wreq),
    .s_waddr(s_waddr),
    .s_wdata(s_wdata),
    .s_wack(s_wack),
    .s_rreq(s_rreq),
    .s_raddr(s_raddr),
    .s_rdata(s_rdata),
    .s_rack(s_rack)
  );

  always #5 up_clk = ~up_clk;

  // a = cycle the slaves ack (0 = never), dup = cycle of an illegal re-request
  typedef struct packed {
    logic                en;
    logic [AW-1:0]       addr;
    logic [31:0]         wdata;
    logic [7:0]          a;
    logic [NS-1:0]       mask;
    logic [NS-1:0][31:0] d;
    logic [7:0]          dup;
  } stim_t;

  int n_chk  = 0;
  int n_fail = 0;
  int m_tmo  = 0;
  int m_col  = 0;
  int m_late = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bump(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic bit is_local(input logic [AW-1:0] a);
    return STATS && (a == LADDR);
  endfunction

  function automatic bit is_real(input stim_t s);
    return s.mask != 0 && s.a >= 1 && int'(s.a) <= T;
  endfunction

  function automatic int exp_cyc(input stim_t s);
    if (is_local(s.addr)) return 2;
    if (is_real(s)) return int'(s.a) + 1;
    return T + 1;
  endfunction

  function automatic logic [31:0] or_data(input stim_t s);
    logic [31:0] r = '0;
    for (int k = 0; k < NS; k++) if (s.mask[k]) r = r | s.d[k];
    return r;
  endfunction

  task automatic model(input stim_t s, input bit rd,
                       output logic [31:0] ed);
    int tmo8 = m_tmo, col8 = m_col, late8 = m_late;
    ed = '0;
    if (!s.en) return;
    if (is_local(s.addr)) begin
      ed = {8'd0, late8[7:0], col8[7:0], tmo8[7:0]};
      if (!rd && s.wdata[0]) begin
        m_tmo = 0; m_col = 0; m_late = 0;
      end
    end else if (is_real(s)) begin
      ed = or_data(s);
      if ($countones(s.mask) > 1) m_col = bump(m_col);
    end else begin
      ed = ERR;
      m_tmo = bump(m_tmo);
      if (s.mask != 0 && int'(s.a) > T) m_late = bump(m_late);
    end
  endtask

  function automatic stim_t mk(input logic [AW-1:0] addr,
                               input logic [31:0] wd, input int a,
                               input logic [NS-1:0] mask,
                               input logic [NS-1:0][31:0] d);
    stim_t s;
    s.en = 1'b1; s.addr = addr; s.wdata = wd; s.a = 8'(a);
    s.mask = mask; s.d = d; s.dup = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = mk(AW'($urandom_range(0, 32'h3FFE)), $urandom,
           $urandom_range(1, T + 4), NS'($urandom),
           {$urandom, $urandom, $urandom, $urandom});
    if ($urandom_range(0, 2) == 0) s.dup = 8'($urandom_range(1, exp_cyc(s)));
    return s;
  endfunction

  task automatic run(input string tag, input stim_t w, input stim_t r);
    int ncyc = T + 8;
    int wa = 0, ra = 0, wac = -1, rac = -1;
    int ws = 0, rs = 0, wsc = -1, rsc = -1, rbad = 0;
    logic [AW-1:0] wsa = '0, rsa = '0;
    logic [31:0] wsd = '0, rd_at = '0, ew, er;
    model(w, 1'b0, ew);
    model(r, 1'b1, er);
    for (int c = 0; c < ncyc; c++) begin
      up_wreq  = w.en && (c == 0 || (w.dup != 0 && c == int'(w.dup)));
      up_rreq  = r.en && (c == 0 || (r.dup != 0 && c == int'(r.dup)));
      up_waddr = w.addr;
      up_wdata = w.wdata;
      up_raddr = r.addr;
      s_wack   = (w.en && w.a != 0 && c == int'(w.a)) ? w.mask : '0;
      s_rack   = (r.en && r.a != 0 && c == int'(r.a)) ? r.mask : '0;
      s_rdata  = '0;
      for (int k = 0; k < NS; k++)
        if (s_rack[k]) s_rdata[32*k +: 32] = r.d[k];
      @(negedge up_clk);
      if (up_wack) begin wa++; wac = c; end
      if (up_rack) begin ra++; rac = c; rd_at = up_rdata; end
      else if (up_rdata != 0) rbad++;
      if (s_wreq) begin ws++; wsc = c; wsa = s_waddr; wsd = s_wdata; end
      if (s_rreq) begin rs++; rsc = c; rsa = s_raddr; end
      @(posedge up_clk);
      #1;
    end
    up_wreq = 1'b0; up_rreq = 1'b0; s_wack = '0; s_rack = '0; s_rdata = '0;
    if (w.en) begin
      check({tag, ".wack_cnt"}, wa, 1);
      check({tag, ".wack_cyc"}, wac, exp_cyc(w));
      check({tag, ".s_wreq_cnt"}, ws, 1);
      check({tag, ".s_wreq_cyc"}, wsc, 1);
      check({tag, ".s_waddr"}, wsa, w.addr);
      check({tag, ".s_wdata"}, wsd, w.wdata);
    end else begin
      check({tag, ".wack_none"}, wa, 0);
      check({tag, ".s_wreq_none"}, ws, 0);
    end
    if (r.en) begin
      check({tag, ".rack_cnt"}, ra, 1);
      check({tag, ".rack_cyc"}, rac, exp_cyc(r));
      check({tag, ".rdata"}, rd_at, er);
      check({tag, ".s_rreq_cnt"}, rs, 1);
      check({tag, ".s_rreq_cyc"}, rsc, 1);
      check({tag, ".s_raddr"}, rsa, r.addr);
    end else begin
      check({tag, ".rack_none"}, ra, 0);
      check({tag, ".s_rreq_none"}, rs, 0);
    end
    check({tag, ".rdata_idle"}, rbad, 0);
  endtask

  stim_t none;
  stim_t sw, sr;
  int    seen;
  int    sel;

  initial begin
    none     = '0;
    up_rstn  = 1'b0;
    up_wreq  = 1'b0;
    up_rreq  = 1'b0;
    up_waddr = '0;
    up_wdata = '0;
    up_raddr = '0;
    s_wack   = '0;
    s_rack   = '0;
    s_rdata  = '0;
    repeat (3) @(posedge up_clk);
    @(negedge up_clk);
    check("reset.up_wack", up_wack, 0);
    check("reset.up_rack", up_rack, 0);
    check("reset.up_rdata", up_rdata, 0);
    check("reset.s_wreq", s_wreq, 0);
    check("reset.s_rreq", s_rreq, 0);
    check("reset.s_waddr", s_waddr, 0);
    up_rstn = 1'b1;
    @(posedge up_clk);
    #1;

    run("rd_slave2", none,
        mk(14'h123, 0, 4, 4'b0100, {32'h0, 32'h12345678, 32'h0, 32'h0}));
    run("wr_timeout", mk(14'h3000, 32'hCAFE0001, 0, 4'b0000, '0), none);
    run("rd_late", none,
        mk(14'h0200, 0, T + 3, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h55}));
    sr = mk(14'h20, 0, 5, 4'b0011, {32'h0, 32'h0, 32'h0F00, 32'h00F0});
    run("wr_rd_same", mk(14'h10, 32'h0BADF00D, 3, 4'b0001, '0), sr);
    run("rd_expiry", none,
        mk(14'h0040, 0, T, 4'b1000, {32'hA5A5_0001, 32'h0, 32'h0, 32'h0}));
    sr = mk(14'h0041, 0, 6, 4'b0010, {32'h0, 32'h0, 32'h7777, 32'h0});
    sr.dup = 8'd3;
    run("rd_dup", none, sr);
    sw = mk(14'h0042, 32'h1, 0, 4'b0000, '0);
    sw.dup = 8'(T);
    run("wr_dup_tmo", sw, none);
    // late=1, collision=1, timeout=3 in the stats build
    run("stats1", none, mk(LADDR, 0, 0, 4'b0000, '0));
    run("clear", mk(LADDR, 32'h1, 0, 4'b0000, '0), none);
    run("stats0", none, mk(LADDR, 0, 0, 4'b0000, '0));
    for (int i = 0; i < 3; i++)
      run("tmo3", mk(14'h0100, 32'h0, 0, 4'b0000, '0), none);
    run("stats3", none, mk(LADDR, 0, 0, 4'b0000, '0));

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      sw  = sel[0] ? rnd() : none;
      sr  = sel[1] ? rnd() : none;
      run("rand", sw, sr);
    end
    run("stats_rand", none, mk(LADDR, 0, 0, 4'b0000, '0));

    // reset mid-transaction: no ack, counters back to 0
    up_rreq  = 1'b1;
    up_raddr = 14'h55;
    @(posedge up_clk);
    #1;
    up_rreq = 1'b0;
    repeat (2) @(posedge up_clk);
    #3;
    up_rstn = 1'b0;
    #1;
    check("rst.s_rreq", s_rreq, 0);
    check("rst.up_rack", up_rack, 0);
    @(negedge up_clk);
    up_rstn = 1'b1;
    seen = 0;
    repeat (T + 6) begin
      @(negedge up_clk);
      if (up_rack) seen++;
    end
    check("rst.no_rack", seen, 0);
    m_tmo = 0; m_col = 0; m_late = 0;
    @(posedge up_clk);
    #1;
    run("stats_rst", none, mk(LADDR, 0, 0, 4'b0000, '0));

    for (int i = 0; i < 150; i++)
      run("sat", mk(14'h0300, 32'h0, 0, 4'b0000, '0),
          mk(14'h0301, 0, 0, 4'b0000, '0));
    run("stats_sat", none, mk(LADDR, 0, 0, 4'b0000, '0));
    run("clear2", mk(LADDR, 32'h1, 0, 4'b0000, '0), none);
    run("stats_clr", none, mk(LADDR, 0, 0, 4'b0000, '0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
